ofmap_writeback: RTL and testbench
==================================

// Module: ofmap_writeback
// PURPOSE
//  Sits directly downstream of the accumulator FIFOs. Takes quantized ofmap rows (PE_SIZE x DATA_WIDTH) and
//  their valid strobe, applies optional per-lane ReLU, and buffers rows in a small FIFO. Drains the FIFO to
//  the global buffer (GLB) write port with a valid/ready handshake and a sequential address counter.
//  Signals done once every row of one output tile has been written. Upstream has no backpressure.
// PARAMETERS
//  PE_SIZE      4    lanes per ofmap row
//  DATA_WIDTH   8    bits per lane, signed two's complement
//  OFMAP_ROWS   70   rows per tile, equal to WEIGHT_COL_NUM of the accumulator
//  BUF_DEPTH    4    row buffer entries, power of two, >=2
//  ADDR_WIDTH   16   GLB word address width
// PORTS
//  clk           in   1                    clock, all logic on rising edge
//  rst           in   1                    asynchronous reset, active-high
//  start_i       in   1                    1-cycle pulse, arms a tile (honoured only in IDLE)
//  base_addr_i   in   ADDR_WIDTH           GLB start address, sampled on start_i
//  relu_en_i     in   1                    ReLU enable, sampled on start_i
//  ofmap_row_i   in   DATA_WIDTH*PE_SIZE   row data, lane k at [DATA_WIDTH*(PE_SIZE-k)-1 -: DATA_WIDTH]
//  ofmap_valid_i in   1                    row present this cycle
//  glb_wren_o    out  1                    write request (valid)
//  glb_ready_i   in   1                    GLB accepts; transfer = glb_wren_o & glb_ready_i
//  glb_waddr_o   out  ADDR_WIDTH           write address
//  glb_wdata_o   out  DATA_WIDTH*PE_SIZE   write data, same lane order as ofmap_row_i
//  busy_o        out  1                    state != IDLE
//  done_o        out  1                    1-cycle pulse, tile complete
//  overflow_o    out  1                    sticky: a row was dropped on a full buffer
// BEHAVIOUR
//  Reset: state=IDLE, buffer empty, all counters 0. All outputs 0, including glb_waddr_o and glb_wdata_o.
//  FSM IDLE -> RUN on start_i: latch base/relu, clear row_cnt, wr_cnt and overflow_o.
//   RUN -> DRAIN when the OFMAP_ROWS-th row is accepted.
//   DRAIN -> DONE when wr_cnt reaches OFMAP_ROWS (last transfer).
//   DONE -> IDLE unconditionally; done_o=1 only in DONE.
//   start_i outside IDLE is ignored.
//  Ingress: accepted only in RUN when ofmap_valid_i=1. Rows in IDLE/DRAIN/DONE are dropped, not counted,
//   and do not set overflow.
//  ReLU: applied at ingress, per lane. If relu_en and lane msb=1, the lane becomes 0; else it passes unchanged.
//  Buffer: push at the accepting edge. Push on full is allowed if a pop happens the same cycle; otherwise
//   the row is dropped, row_cnt still increments, and overflow_o is set until the next start_i.
//  Egress: show-ahead. glb_wren_o = !empty in RUN/DRAIN; glb_wdata_o = head entry;
//   glb_waddr_o = base + wr_cnt (wraps mod 2^ADDR_WIDTH). On transfer: pop, wr_cnt++.
//   With the buffer empty, a row accepted at edge N gives glb_wren_o=1 in the cycle after N.
//   glb_wren_o is held with stable data/address until glb_ready_i.
//  After an overflow, fewer than OFMAP_ROWS rows are buffered, so DRAIN -> DONE also fires when
//   row_cnt==OFMAP_ROWS and the buffer is empty; wr_cnt then reports the written count.
//  Asserting rst mid-tile aborts immediately: buffered rows are lost, no done_o.
// STRUCTURE
//  Shared package/include: FSM state encodings (IDLE/RUN/DRAIN/DONE, 2 bits) and the lane slicing macro
//   shared with the accumulator.
//  One sub-module: ofmap_wb_fifo (sync FIFO, DATA_WIDTH*PE_SIZE wide, BUF_DEPTH deep, show-ahead,
//   simultaneous push/pop when full).
//  The top holds the FSM, counters, ReLU and address generation.
// TESTING
//  1 Base: start base=0x100, relu=0, ready=1, 70 rows with lane0=i -> 70 writes at addresses 0x100..0x145,
//    data in order, done_o one cycle after the last write, overflow_o=0.
//  2 ReLU: relu=1, row {0x80,0x7F,0xFF,0x01} -> wdata {0x00,0x7F,0x00,0x01}; with relu=0 it passes unchanged.
//  3 Backpressure: ready=0 for 4 valid rows -> buffer full, no drop. 5th row -> overflow_o=1,
//    then 4 writes once ready returns.
//  4 Full with simultaneous pop: ready=1 while full, continuous valid -> no drop, 1 row per cycle throughput.
//  5 Wrap: base=0xFFFE, 4 rows (OFMAP_ROWS=4) -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
//  6 Reset mid-RUN at row 30 -> outputs 0 next cycle, no done_o.
//    New start -> clean 70-row tile; valid in IDLE is ignored.

Source files
------------

// File: rtl/ofmap_writeback_pkg.sv
// ofmap_writeback_pkg: shared FSM encoding, lane slicing and default sizing for the ofmap writeback path
`ifndef OFMAP_LANE
`define OFMAP_LANE(k, w, n) (w)*((n)-(k))-1 -: (w)
`endif
package ofmap_writeback_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_e;
    localparam int DEF_PE_SIZE    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OFMAP_ROWS = 70;
    localparam int DEF_BUF_DEPTH  = 4;
    localparam int DEF_ADDR_WIDTH = 16;
endpackage

// File: rtl/ofmap_writeback_if.sv
// ofmap_writeback_if: GLB write port, valid/ready handshake with address and row data
interface ofmap_writeback_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_BITS  = 32
);
    logic                  wren;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_BITS-1:0]  wdata;
    modport master (output wren, waddr, wdata, input ready);
    modport slave (input wren, waddr, wdata, output ready);
endinterface

// File: rtl/ofmap_wb_fifo.sv
// ofmap_wb_fifo: show-ahead sync row buffer that accepts a push on full when a pop happens the same cycle
module ofmap_wb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0] cnt;
    logic do_push;
    logic do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = cnt[PW];
    assign empty   = cnt == '0;
    assign head    = mem[rp];
    // pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end
    // row storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: ReLU, buffer and write one tile of ofmap rows to the GLB with sequential addresses
module ofmap_writeback
    import ofmap_writeback_pkg::*;
#(
    parameter int PE_SIZE    = DEF_PE_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OFMAP_ROWS = DEF_OFMAP_ROWS,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic                          relu_en_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    ofmap_writeback_if.master             glb,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);
    localparam int ROW_W = DATA_WIDTH * PE_SIZE;
    localparam int CNT_W = $clog2(OFMAP_ROWS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OFMAP_ROWS - 1);
    wb_state_e state;
    wb_state_e state_nx;
    logic [ADDR_WIDTH-1:0] base;
    logic relu;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [ROW_W-1:0] row_relu;
    logic [ROW_W-1:0] head;
    logic full;
    logic empty;
    logic wren;
    logic accept;
    logic xfer;
    logic drop;

    assign accept = state == RUN && ofmap_valid_i;
    assign xfer   = wren && glb.ready;
    assign drop   = accept && full && !xfer;

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_relu
        assign row_relu[`OFMAP_LANE(k, DATA_WIDTH, PE_SIZE)] =
            (relu && ofmap_row_i[DATA_WIDTH*(PE_SIZE-k)-1]) ? '0 : ofmap_row_i[`OFMAP_LANE(k, DATA_WIDTH, PE_SIZE)];
    end

    ofmap_wb_fifo #(
        .WIDTH(ROW_W),
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .pop  (xfer),
        .din  (row_relu),
        .head (head),
        .full (full),
        .empty(empty)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // next state: an overflowed tile never reaches the full write count, so an empty buffer also ends DRAIN
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start_i) state_nx = RUN;
            RUN:   if (accept && row_cnt == LAST) state_nx = DRAIN;
            DRAIN: if (empty || (xfer && wr_cnt == LAST)) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    // outputs: data is forced to zero while no write is offered so stale buffer contents never leak out
    always_comb begin
        wren   = (state == RUN || state == DRAIN) && !empty;
        busy_o = state != IDLE;
        done_o = state == DONE;
    end

    assign glb.wren  = wren;
    assign glb.waddr = base + ADDR_WIDTH'(wr_cnt);
    assign glb.wdata = wren ? head : '0;

    // tile context and counters: armed by start_i in IDLE, then advanced by accepted rows and GLB transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base       <= '0;
            relu       <= 1'b0;
            row_cnt    <= '0;
            wr_cnt     <= '0;
            overflow_o <= 1'b0;
        end else if (state == IDLE && start_i) begin
            base       <= base_addr_i;
            relu       <= relu_en_i;
            row_cnt    <= '0;
            wr_cnt     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (accept) row_cnt <= row_cnt + 1'b1;
            if (xfer) wr_cnt <= wr_cnt + 1'b1;
            if (drop) overflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofmap_writeback.sv
// tb_ofmap_writeback: directed self-checking bench for ofmap_writeback
module tb_ofmap_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, relu_a = 1'b0, valid_a = 1'b0, busy_a, done_a, ovf_a;
    logic [15:0] base_a = '0;
    logic [31:0] row_a = '0;
    logic start_b = 1'b0, relu_b = 1'b0, valid_b = 1'b0, busy_b, done_b, ovf_b;
    logic [15:0] base_b = '0;
    logic [31:0] row_b = '0;

    ofmap_writeback_if #(.ADDR_WIDTH(16), .DATA_BITS(32)) bus_a ();
    ofmap_writeback_if #(.ADDR_WIDTH(16), .DATA_BITS(32)) bus_b ();

    ofmap_writeback dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .base_addr_i(base_a), .relu_en_i(relu_a),
        .ofmap_row_i(row_a), .ofmap_valid_i(valid_a), .glb(bus_a),
        .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a)
    );

    ofmap_writeback #(.OFMAP_ROWS(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .base_addr_i(base_b), .relu_en_i(relu_b),
        .ofmap_row_i(row_b), .ofmap_valid_i(valid_b), .glb(bus_b),
        .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] la_addr [1024];
    logic [31:0] la_data [1024];
    int la_cyc [1024];
    int na = 0, nda = 0, done_cyc_a = 0;
    logic [15:0] lb_addr [64];
    logic [31:0] lb_data [64];
    int nb = 0, ndb = 0;

    always @(negedge clk) begin
        if (bus_a.wren && bus_a.ready) begin
            la_addr[na] = bus_a.waddr;
            la_data[na] = bus_a.wdata;
            la_cyc[na] = cyc;
            na = na + 1;
        end
        if (done_a) begin
            nda = nda + 1;
            done_cyc_a = cyc;
        end
        if (bus_b.wren && bus_b.ready) begin
            lb_addr[nb] = bus_b.waddr;
            lb_data[nb] = bus_b.wdata;
            nb = nb + 1;
        end
        if (done_b) ndb = ndb + 1;
    end

    logic [31:0] rb [4] = '{32'h807FFF01, 32'h01020304, 32'hFF000080, 32'h7F817F81};
    logic [31:0] rb_relu [4] = '{32'h007F0001, 32'h01020304, 32'h00000000, 32'h7F007F00};
    logic [15:0] wrap_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    function automatic logic [31:0] mkrow(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, 8'hA5, 8'h00, ~b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile_a(input logic [15:0] base, input logic relu);
        base_a = base;
        relu_a = relu;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        relu_a = 1'b0;
    endtask

    task automatic send_rows_a(input int from, input int to, input int glitch);
        for (int i = from; i < to; i++) begin
            valid_a = 1'b1;
            row_a = mkrow(i);
            start_a = (i == glitch);
            if (i == glitch) begin
                base_a = 16'h0999;
                relu_a = 1'b1;
            end
            step();
        end
        valid_a = 1'b0;
        start_a = 1'b0;
        relu_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int prev;
        int n;
        prev = nda;
        n = 0;
        while (nda == prev && n < 40) begin
            step();
            n++;
        end
        chk(tag, 64'(nda - prev), 64'd1);
    endtask

    task automatic wait_done_b(input string tag);
        int prev;
        int n;
        prev = ndb;
        n = 0;
        while (ndb == prev && n < 40) begin
            step();
            n++;
        end
        chk(tag, 64'(ndb - prev), 64'd1);
    endtask

    task automatic check_log_a(input string tag, input int first, input int n, input logic [15:0] base, input int skip);
        for (int j = 0; j < n; j++) begin
            int r;
            r = (skip >= 0 && j >= skip) ? j + 1 : j;
            chk($sformatf("%s_w%0d", tag, j), {16'h0, la_addr[first+j], la_data[first+j]},
                {16'h0, base + 16'(j), mkrow(r)});
        end
    endtask

    task automatic tile_b(input string tag, input logic [15:0] base, input logic relu);
        int ib;
        ib = nb;
        base_b = base;
        relu_b = relu;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_b = 1'b1;
            row_b = rb[i];
            step();
        end
        valid_b = 1'b0;
        wait_done_b({tag, "_done"});
        chk({tag, "_count"}, 64'(nb - ib), 64'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s_w%0d", tag, j), {16'h0, lb_addr[ib+j], lb_data[ib+j]},
                {16'h0, relu ? wrap_addr[j] : base + 16'(j), relu ? rb_relu[j] : rb[j]});
        end
    endtask

    initial begin
        int ia;
        int pnd;
        bus_a.ready = 1'b0;
        bus_b.ready = 1'b0;
        step();
        step();
        chk("rst_wren", bus_a.wren, 0);
        chk("rst_waddr", bus_a.waddr, 0);
        chk("rst_wdata", bus_a.wdata, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_wren_b", bus_b.wren, 0);
        rst = 1'b0;
        step();

        // base tile with a stray start_i mid-tile that must be ignored
        ia = na;
        bus_a.ready = 1'b1;
        start_tile_a(16'h0100, 1'b0);
        chk("t1_busy", busy_a, 1);
        send_rows_a(0, 70, 10);
        wait_done_a("t1_done");
        chk("t1_count", 64'(na - ia), 64'd70);
        check_log_a("t1", ia, 70, 16'h0100, -1);
        chk("t1_done_lat", 64'(done_cyc_a), 64'(la_cyc[na-1] + 1));
        chk("t1_ovf", ovf_a, 0);
        chk("t1_idle", busy_a, 0);

        // relu on with address wrap, then relu off
        bus_b.ready = 1'b1;
        tile_b("t2_relu", 16'hFFFE, 1'b1);
        tile_b("t2_pass", 16'h0010, 1'b0);

        // backpressure: four rows fill the buffer, the fifth is dropped
        ia = na;
        bus_a.ready = 1'b0;
        start_tile_a(16'h0400, 1'b0);
        send_rows_a(0, 4, -1);
        chk("t3_full_ovf", ovf_a, 0);
        chk("t3_wren", bus_a.wren, 1);
        chk("t3_waddr", bus_a.waddr, 16'h0400);
        chk("t3_wdata", bus_a.wdata, mkrow(0));
        send_rows_a(4, 5, -1);
        chk("t3_ovf", ovf_a, 1);
        step();
        step();
        chk("t3_hold_wren", bus_a.wren, 1);
        chk("t3_hold_waddr", bus_a.waddr, 16'h0400);
        chk("t3_hold_wdata", bus_a.wdata, mkrow(0));
        chk("t3_no_writes", 64'(na - ia), 64'd0);
        bus_a.ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t3_drain4", 64'(na - ia), 64'd4);
        chk("t3_empty_wren", bus_a.wren, 0);
        send_rows_a(5, 70, -1);
        wait_done_a("t3_done");
        chk("t3_count", 64'(na - ia), 64'd69);
        check_log_a("t3", ia, 69, 16'h0400, 4);
        chk("t3_ovf_sticky", ovf_a, 1);

        // full buffer with a pop every cycle: no drop, one write per cycle
        ia = na;
        bus_a.ready = 1'b0;
        start_tile_a(16'h0500, 1'b0);
        chk("t4_ovf_cleared", ovf_a, 0);
        send_rows_a(0, 4, -1);
        bus_a.ready = 1'b1;
        send_rows_a(4, 70, -1);
        wait_done_a("t4_done");
        chk("t4_count", 64'(na - ia), 64'd70);
        check_log_a("t4", ia, 70, 16'h0500, -1);
        chk("t4_ovf", ovf_a, 0);
        chk("t4_rate", 64'(la_cyc[na-1] - la_cyc[ia]), 64'd69);
        chk("t4_done_lat", 64'(done_cyc_a), 64'(la_cyc[na-1] + 1));

        // reset in the middle of a tile, then stray rows in IDLE, then a clean tile
        start_tile_a(16'h0200, 1'b0);
        send_rows_a(0, 30, -1);
        pnd = nda;
        rst = 1'b1;
        step();
        chk("t6_rst_wren", bus_a.wren, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_waddr", bus_a.waddr, 0);
        chk("t6_rst_wdata", bus_a.wdata, 0);
        chk("t6_rst_ovf", ovf_a, 0);
        rst = 1'b0;
        step();
        send_rows_a(50, 53, -1);
        step();
        chk("t6_idle_busy", busy_a, 0);
        chk("t6_idle_wren", bus_a.wren, 0);
        chk("t6_no_done", 64'(nda - pnd), 64'd0);
        ia = na;
        start_tile_a(16'h0300, 1'b0);
        send_rows_a(0, 70, -1);
        wait_done_a("t6_done");
        chk("t6_count", 64'(na - ia), 64'd70);
        check_log_a("t6", ia, 70, 16'h0300, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
